// File: rtl/tristate_bus_ctrl.sv
// tristate_bus_ctrl: per-channel tri-state pin owner with drive/pulse/guard sequencing and a deglitched read path
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   port[CHANNELS]          : bidirectional bus pins
//   drive_en/drive_val      : request to drive a pin and the value to drive
//   pulse_start/pulse_len   : strobe starting a timed low pulse, shared length latched at start
//   read/read_valid         : filtered pin value, high when released and past the guard interval
//   pulse_busy/pulse_done   : pulse (plus its guard) in progress, end-of-pulse strobe
//   TRISTATE_OPEN_DRAIN_EN  : when defined, DRIVE only pulls low and releases for a 1
module tristate_bus_ctrl #(
  parameter int CHANNELS = 1,
  parameter int TURNAROUND = 2,
  parameter int FILTER = 3,
  parameter int PULSE_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  inout  wire  [CHANNELS-1:0] port,
  input  logic [CHANNELS-1:0] drive_en,
  input  logic [CHANNELS-1:0] drive_val,
  input  logic [CHANNELS-1:0] pulse_start,
  input  logic [PULSE_W-1:0]  pulse_len,
  output logic [CHANNELS-1:0] read,
  output logic [CHANNELS-1:0] read_valid,
  output logic [CHANNELS-1:0] pulse_busy,
  output logic [CHANNELS-1:0] pulse_done
);
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, PULSE = 2'd2, GUARD = 2'd3;
  localparam int GW = $clog2(TURNAROUND + 2);
  localparam int FW = $clog2(FILTER + 1);
  // with no guard interval the release goes straight back to IDLE
  localparam logic [1:0] EXIT = (TURNAROUND == 0) ? IDLE : GUARD;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0] st, nxt;
    logic [PULSE_W-1:0] cnt;
    logic [GW-1:0] gcnt;
    logic [FW-1:0] fcnt;
    logic [1:0] sync;
    logic oe, ov, busy, done, rv, rd, last, start, zero;
    assign last = cnt == PULSE_W'(1);
    assign start = pulse_start[i] && pulse_len != '0;
    assign zero = pulse_start[i] && pulse_len == '0;
    always_comb begin
      nxt = st == IDLE  ? (start ? PULSE : (!pulse_start[i] && drive_en[i]) ? DRIVE : IDLE) :
            st == DRIVE ? (drive_en[i] ? DRIVE : EXIT) :
            st == PULSE ? (last ? EXIT : PULSE) :
            (gcnt == '0 ? IDLE : GUARD);
    end
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        st   <= IDLE;
        cnt  <= '0;
        gcnt <= '0;
        oe   <= 1'b0;
        ov   <= 1'b0;
        busy <= 1'b0;
        done <= 1'b0;
        rv   <= 1'b0;
        sync <= 2'b11;
        fcnt <= '0;
        rd   <= 1'b1;
      end else begin
        st   <= nxt;
        // cnt tracks pulse_len outside PULSE, so the value present at start is the one counted down
        cnt  <= st == PULSE ? cnt - PULSE_W'(1) : pulse_len;
        gcnt <= st == GUARD ? gcnt - GW'(1) : GW'(TURNAROUND - 1);
`ifdef TRISTATE_OPEN_DRAIN_EN
        oe   <= nxt == PULSE || (nxt == DRIVE && !drive_val[i]);
        ov   <= 1'b0;
`else
        oe   <= nxt == PULSE || nxt == DRIVE;
        ov   <= nxt == DRIVE && drive_val[i];
`endif
        busy <= nxt == PULSE || (nxt == GUARD && (st == PULSE || busy));
        done <= (st == PULSE && last) || (st == IDLE && zero);
        rv   <= nxt == IDLE;
        sync <= {sync[0], port[i]};
        // read flips only on the FILTER-th consecutive differing sample
        rd   <= (sync[1] != rd && fcnt == FW'(FILTER - 1)) ? sync[1] : rd;
        fcnt <= (sync[1] == rd || fcnt == FW'(FILTER - 1)) ? '0 : fcnt + FW'(1);
      end
    end
    assign port[i] = oe ? ov : 1'bz;
    assign read[i] = rd;
    assign read_valid[i] = rv;
    assign pulse_busy[i] = busy;
    assign pulse_done[i] = done;
  end
endmodule
